// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite row fetch path and its neighbours
// (renderer, collision logic).
package sprite_pkg;
  localparam int NUM_SPRITES = 8;
  localparam int SPR_W       = 32;
  localparam int SPR_H       = 32;
  localparam int ROM_AW      = 13;
  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int SLOT_W      = $clog2(NUM_SPRITES);
  localparam int COL_W       = $clog2(SPR_W);

  typedef enum logic [2:0] {IDLE, SCAN, FETCH, DRAIN, DONE} fetch_state_t;
  typedef logic [SLOT_W-1:0] slot_idx_t;
  typedef logic [COL_W-1:0]  col_idx_t;
endpackage

// File: rtl/sprite_row_fetch_scheduler_if.sv
// Sprite ROM read port plus line-buffer write port, as seen by the fetch scheduler.
interface sprite_row_fetch_scheduler_if;
  import sprite_pkg::*;
  logic [ROM_AW-1:0] rom_address;
  logic [3:0]        rom_q;
  logic              wr_en;
  slot_idx_t         wr_slot;
  col_idx_t          wr_col;
  logic [3:0]        wr_idx;

  modport master (output rom_address, input rom_q,
                  output wr_en, wr_slot, wr_col, wr_idx);
  modport slave  (input rom_address, output rom_q,
                  input wr_en, wr_slot, wr_col, wr_idx);
endinterface

// File: rtl/sprite_row_hit.sv
// Does a sprite with top row sy cover scanline ny, and which of its rows is it.
module sprite_row_hit
  import sprite_pkg::*;
(
  input  logic [9:0] ny,
  input  logic [9:0] sy,
  input  logic       en,
  output logic       hit,
  output logic [9:0] row
);
  assign row = ny - sy;
  // ny >= sy guard keeps a wrapped difference from looking like a small row
  assign hit = en && (ny >= sy) && (row < 10'(SPR_H));
endmodule

// File: rtl/sprite_row_fetch_scheduler.sv
// Per-scanline sprite ROM sequencer: scans all slots against a snapshot of the
// game state and streams each hit slot's pixel row into the line buffer.
module sprite_row_fetch_scheduler
  import sprite_pkg::*;
(
  input  logic                          vga_clk,
  input  logic                          Reset,
  input  logic                          line_start,
  input  logic [9:0]                    next_y,
  input  logic [NUM_SPRITES-1:0]        sprite_en,
  input  logic [NUM_SPRITES*10-1:0]     sprite_y,
  input  logic [NUM_SPRITES*ROM_AW-1:0] sprite_base,
  sprite_row_fetch_scheduler_if.master  bus,
  output logic [NUM_SPRITES-1:0]        slot_hit,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);
  fetch_state_t state;
  slot_idx_t    k;
  col_idx_t     col;

  logic [9:0]                         ny_q;
  logic [NUM_SPRITES-1:0]             en_q;
  logic [NUM_SPRITES-1:0][9:0]        sy_q;
  logic [NUM_SPRITES-1:0][ROM_AW-1:0] base_q;

  logic [NUM_SPRITES-1:0]      hit_v;
  logic [NUM_SPRITES-1:0][9:0] row_v;
  logic [ROM_AW-1:0]           row_base;
  logic                        last_slot;

  for (genvar s = 0; s < NUM_SPRITES; s++) begin : g_hit
    sprite_row_hit u_hit (
      .ny  (ny_q),
      .sy  (sy_q[s]),
      .en  (en_q[s]),
      .hit (hit_v[s]),
      .row (row_v[s])
    );
  end

  assign row_base    = base_q[k] + (ROM_AW'(row_v[k]) << COL_W);
  assign last_slot   = (k == slot_idx_t'(NUM_SPRITES - 1));
  assign bus.wr_idx  = bus.rom_q;

  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state           <= IDLE;
      k               <= '0;
      col             <= '0;
      ny_q            <= '0;
      en_q            <= '0;
      sy_q            <= '0;
      base_q          <= '0;
      bus.rom_address <= '0;
      bus.wr_en       <= 1'b0;
      bus.wr_slot     <= '0;
      bus.wr_col      <= '0;
      slot_hit        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      done      <= 1'b0;
      if (line_start && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: if (line_start) begin
          ny_q     <= next_y;
          en_q     <= sprite_en;
          sy_q     <= sprite_y;
          base_q   <= sprite_base;
          slot_hit <= '0;
          busy     <= 1'b1;
          k        <= '0;
          state    <= SCAN;
        end
        SCAN: begin
          if (hit_v[k]) begin
            slot_hit[k]     <= 1'b1;
            col             <= '0;
            bus.rom_address <= row_base;
            state           <= FETCH;
          end else if (last_slot) begin
            state <= DRAIN;
          end else begin
            k <= k + slot_idx_t'(1);
          end
        end
        FETCH: begin
          // write strobe trails the address by one cycle to line up with rom_q
          bus.wr_en   <= 1'b1;
          bus.wr_slot <= k;
          bus.wr_col  <= col;
          if (col == col_idx_t'(SPR_W - 1)) begin
            if (last_slot) state <= DRAIN;
            else begin
              k     <= k + slot_idx_t'(1);
              state <= SCAN;
            end
          end else begin
            col             <= col + col_idx_t'(1);
            bus.rom_address <= row_base + ROM_AW'(col) + ROM_AW'(1);
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sprite_row_fetch_scheduler.sv
// Directed bench for sprite_row_fetch_scheduler with a closed-form timing model
// of each accepted line and a per-cycle compare process.
module tb_sprite_row_fetch_scheduler;
  import sprite_pkg::*;

  logic vga_clk = 1'b0;
  logic Reset, line_start;
  logic [9:0] ny;
  logic [7:0] en;
  logic [7:0][9:0]  sy_p;
  logic [7:0][12:0] base_p;
  logic [7:0] slot_hit;
  logic busy, done, overrun;

  sprite_row_fetch_scheduler_if bus();

  sprite_row_fetch_scheduler dut (
    .vga_clk(vga_clk), .Reset(Reset), .line_start(line_start), .next_y(ny),
    .sprite_en(en), .sprite_y(sy_p), .sprite_base(base_p), .bus(bus),
    .slot_hit(slot_hit), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic logic [3:0] rom_f(input int a);
    int b;
    b = a & 32'h1FFF;
    return 4'(b ^ (b >> 4) ^ (b >> 8) ^ (b >> 3));
  endfunction

  always @(posedge vga_clk) bus.rom_q <= rom_f(int'(bus.rom_address));

  int n_tests = 0, n_fail = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: expected write stream keyed by absolute cycle, plus line timing.
  typedef struct { int slot; int col; int addr; } wr_t;
  wr_t exp_wr [int];
  int  exp_start = -1, exp_done = -1, ovr_from = -1, t_start = 0;
  logic [7:0] exp_mask = '0;

  task automatic model_reset();
    exp_wr.delete();
    exp_start = -1; exp_done = -1; ovr_from = -1; exp_mask = '0;
  endtask

  task automatic model_line(input int c, output bit acc);
    int hb, row;
    acc = !(exp_done >= 0 && c <= exp_done);
    if (!acc) begin
      if (ovr_from < 0) ovr_from = c + 1;
      return;
    end
    exp_wr.delete();
    exp_start = c; exp_mask = '0; hb = 0;
    for (int s = 0; s < NUM_SPRITES; s++) begin
      row = int'(ny) - int'(sy_p[s]);
      if (en[s] && row >= 0 && row < SPR_H) begin
        exp_mask[s] = 1'b1;
        // slot s is scanned after s earlier scans and hb earlier full rows
        for (int cc = 0; cc < SPR_W; cc++)
          exp_wr[c + s + hb*SPR_W + 3 + cc] = '{s, cc, (int'(base_p[s]) + row*SPR_W + cc) % 8192};
        hb++;
      end
    end
    exp_done = c + NUM_SPRITES + hb*SPR_W + 2;
  endtask

  bit started = 0;
  int prev_addr = 0, n_wr = 0, first_addr = -1, last_addr = -1;
  always @(negedge vga_clk) begin
    bit ew, act;
    if (started && !Reset) begin
      ew = exp_wr.exists(cyc);
      check("wr_en", bus.wr_en, ew);
      if (ew && bus.wr_en) begin
        check("wr_slot", bus.wr_slot, exp_wr[cyc].slot);
        check("wr_col", bus.wr_col, exp_wr[cyc].col);
        check("rom_address", prev_addr, exp_wr[cyc].addr);
        check("wr_idx", bus.wr_idx, rom_f(exp_wr[cyc].addr));
      end
      if (bus.wr_en) begin
        n_wr++;
        if (first_addr < 0) first_addr = prev_addr;
        last_addr = prev_addr;
      end
      check("done", done, exp_done >= 0 && cyc == exp_done);
      act = exp_done >= 0 && cyc > exp_start && cyc < exp_done;
      check("busy", busy, act);
      check("overrun", overrun, ovr_from >= 0 && cyc >= ovr_from);
      if (exp_start < 0) check("slot_hit_idle", slot_hit, 0);
      else if (cyc >= exp_done) check("slot_hit", slot_hit, exp_mask);
    end
    prev_addr = int'(bus.rom_address);
  end

  task automatic line();
    bit acc;
    @(posedge vga_clk); #1;
    line_start = 1'b1;
    model_line(cyc, acc);
    if (acc) t_start = cyc;
    @(posedge vga_clk); #1;
    line_start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int exp_lat);
    int lat;
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge vga_clk);
      if (done) begin lat = cyc - t_start; break; end
    end
    check(nm, lat, exp_lat);
  endtask

  task automatic clr_stats();
    n_wr = 0; first_addr = -1; last_addr = -1;
  endtask

  task automatic cfg_all8();
    en = 8'hFF; ny = 10'd200;
    for (int s = 0; s < 8; s++) begin
      sy_p[s] = 10'd200; base_p[s] = 13'(s * 13'h300);
    end
  endtask

  task automatic cfg_slot2();
    en = 8'h04; sy_p = '0; base_p = '0; ny = 10'd105;
    sy_p[2] = 10'd100; base_p[2] = 13'h400;
  endtask

  initial begin
    logic [7:0] t_en[9], t_mask[9];
    int t_sy0[9], t_sy1[9], t_ny[9], t_base[9], t_first[9];
    int dcnt;
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] t_en[9], t_mask[9];
    int t_sy0[9], t_sy1[9], t_ny[9], t_base[9], t_first[9];
    int dcnt;
    t_en  = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h02, 8'h01, 8'h01, 8'h01, 8'h01};
    t_sy0 = '{50,    50,    50,    50,    50,    0,     1000,  50,     500};
    t_sy1 = '{0,     0,     0,     0,     60,    0,     0,     0,      0};
    t_ny  = '{49,    50,    81,    82,    10,    0,     5,     51,     V_TOTAL-1};
    t_base= '{'h100, 'h100, 'h100, 'h100, 0,     'h200, 0,     'h1FF0, 0};
    t_mask= '{8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01,  8'h01};
    t_first='{-1,    'h100, 'h4E0, -1,    -1,    'h200, -1,    'h010,  'h300};

    Reset = 1'b1; line_start = 1'b0; ny = '0; en = '0; sy_p = '0; base_p = '0;
    repeat (3) @(posedge vga_clk);
    #1; Reset = 1'b0; model_reset(); started = 1;
    @(negedge vga_clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_slot_hit", slot_hit, 0);
    check("reset_overrun", overrun, 0);

    // single sprite in slot 2
    cfg_slot2(); clr_stats();
    line();
    wait_done("slot2_latency", 42);
    check("slot2_writes", n_wr, 32);
    check("slot2_first_addr", first_addr, 'h4A0);
    check("slot2_last_addr", last_addr, 'h4BF);
    check("slot2_mask", slot_hit, 8'h04);

    // all eight slots hit: worst-case line
    cfg_all8(); clr_stats();
    line();
    wait_done("all8_latency", 266);
    check("all8_writes", n_wr, 256);
    check("all8_mask", slot_hit, 8'hFF);
    check("all8_fits_line", (266 < H_TOTAL), 1);

    // boundary rows, no-wrap, base wraparound
    for (int i = 0; i < 9; i++) begin
      en = t_en[i]; sy_p = '0; base_p = '0;
      sy_p[0] = 10'(t_sy0[i]); sy_p[1] = 10'(t_sy1[i]);
      base_p[0] = 13'(t_base[i]); ny = 10'(t_ny[i]);
      clr_stats();
      line();
      wait_done($sformatf("bound%0d_latency", i), 10 + 32 * $countones(t_mask[i]));
      check($sformatf("bound%0d_mask", i), slot_hit, t_mask[i]);
      check($sformatf("bound%0d_first", i), first_addr, t_first[i]);
    end

    // overlapping line_start during a long fetch
    cfg_all8(); clr_stats();
    line();
    repeat (18) @(posedge vga_clk);
    line();
    wait_done("ovr_latency", 266);
    check("ovr_writes", n_wr, 256);
    check("ovr_flag", overrun, 1);
    clr_stats();
    line();
    @(negedge vga_clk);
    check("ovr_next_accepted", busy, 1);
    wait_done("ovr_next_latency", 266);
    check("ovr_sticky", overrun, 1);

    // reset in the middle of a row fetch (FETCH col 10)
    cfg_slot2(); clr_stats();
    line();
    repeat (13) @(posedge vga_clk);
    #1; Reset = 1'b1; model_reset();
    @(posedge vga_clk); #1; Reset = 1'b0;
    @(negedge vga_clk);
    check("midrst_wr_en", bus.wr_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_slot_hit", slot_hit, 0);
    check("midrst_overrun", overrun, 0);
    dcnt = 0;
    repeat (40) begin @(negedge vga_clk); if (done) dcnt++; end
    check("midrst_no_done", dcnt, 0);
    clr_stats();
    line();
    wait_done("midrst_refetch_latency", 42);
    check("midrst_refetch_writes", n_wr, 32);

    // sprite_y changes right after the accepted line_start
    cfg_slot2(); clr_stats();
    line();
    sy_p[2] = 10'd90;
    wait_done("snap_latency", 42);
    check("snap_first_addr", first_addr, 'h4A0);
    check("snap_last_addr", last_addr, 'h4BF);

    repeat (3) @(posedge vga_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
